// File: rtl/axis_pkt_tx_pkg.sv
// Shared types and constants for the AXI-Stream packet transmitter.
//   DATA_W / DEST_W / USER_W : stream field widths
//   USER_FIRST               : TUSER value carried by the first beat of a packet
//   tx_state_t               : packet-position state (FIRST word pending / BODY words)
//   dest_of()                : extracts the destination byte from a packet's first word
package axis_pkt_tx_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 8;
  localparam int USER_W = 4;

  localparam logic [USER_W-1:0] USER_FIRST = 4'b0001;

  typedef enum logic [0:0] {
    FIRST = 1'b0,
    BODY  = 1'b1
  } tx_state_t;

  function automatic logic [DEST_W-1:0] dest_of(input logic [DATA_W-1:0] word);
    return word[DATA_W-1:DATA_W-DEST_W];
  endfunction

endpackage

// File: rtl/axis_pkt_tx_if.sv
// AXI-Stream bundle used between the packet transmitter and the fabric.
//   master : drives tvalid/tdata/tlast/tdest/tuser, samples tready
//   slave  : the mirror view
interface AXIStream;
  import axis_pkt_tx_pkg::*;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, output tdata, output tlast, output tdest, output tuser,
                  input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tdest, input tuser,
                  output tready);
endinterface

// File: rtl/axis_pkt_tx_fifo.sv
// Synchronous word FIFO for the packet transmitter.
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data   : write request and data; ignored while full
//   pop, rd_data    : read request; rd_data shows the head entry; ignored while empty
//   full, empty     : occupancy flags for the current cycle
//   full_next       : occupancy flag as it will be after this edge
module axis_pkt_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             full_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_next_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign full_next = (count_next_s == CNT_FULL);

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Read/write pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/axis_pkt_tx.sv
// AXI-Stream packet transmitter: buffers {last, word} pushes and emits them as
// stream beats with TDEST from the first word's top byte, TUSER[0] on the first
// beat and TLAST on the final beat.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : word push handshake
//   in_data, in_last    : pushed word and end-of-packet flag
//   m_axis              : AXI-Stream master (registered outputs)
//   busy                : words buffered or a beat pending
//   pkt_count           : packets fully sent, wraps
module axis_pkt_tx
  import axis_pkt_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  AXIStream.master          m_axis,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
);

  logic              in_ready_r;
  logic              push_s;
  logic              pop_s;
  logic              hs_s;
  logic              load_s;
  logic              full_s;
  logic              empty_s;
  logic              full_next_s;
  logic [DATA_W:0]   head_s;
  logic [DATA_W-1:0] head_data_s;
  logic              head_last_s;

  tx_state_t         state_r;
  tx_state_t         state_next_s;
  logic [DEST_W-1:0] dest_r;
  logic [DEST_W-1:0] beat_dest_s;
  logic [USER_W-1:0] beat_user_s;

  logic              tvalid_r;
  logic [DATA_W-1:0] tdata_r;
  logic              tlast_r;
  logic [DEST_W-1:0] tdest_r;
  logic [USER_W-1:0] tuser_r;
  logic [CNT_W-1:0]  pkt_count_r;

  // in_ready is registered so it stays low through reset; being !full it
  // refuses a push at full even when a pop happens in the same cycle.
  assign push_s      = in_valid && in_ready_r;
  assign hs_s        = tvalid_r && m_axis.tready;
  assign load_s      = !tvalid_r || m_axis.tready;
  assign pop_s       = load_s && !empty_s;
  assign head_data_s = head_s[DATA_W-1:0];
  assign head_last_s = head_s[DATA_W];

  axis_pkt_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .wr_data   ({in_last, in_data}),
    .pop       (pop_s),
    .rd_data   (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .full_next (full_next_s)
  );

  // Sideband for the beat about to be loaded, and the packet position after it.
  always_comb begin
    beat_user_s  = {USER_W{1'b0}};
    beat_dest_s  = dest_r;
    state_next_s = state_r;
    case (state_r)
      FIRST: begin
        beat_user_s  = USER_FIRST;
        beat_dest_s  = dest_of(head_data_s);
        state_next_s = head_last_s ? FIRST : BODY;
      end
      BODY: begin
        beat_user_s  = {USER_W{1'b0}};
        beat_dest_s  = dest_r;
        state_next_s = head_last_s ? FIRST : BODY;
      end
      default: begin
        beat_user_s  = USER_FIRST;
        beat_dest_s  = dest_of(head_data_s);
        state_next_s = FIRST;
      end
    endcase
  end

  // Output beat register, packet FSM, destination latch and packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      state_r     <= FIRST;
      dest_r      <= {DEST_W{1'b0}};
      tvalid_r    <= 1'b0;
      tdata_r     <= {DATA_W{1'b0}};
      tlast_r     <= 1'b0;
      tdest_r     <= {DEST_W{1'b0}};
      tuser_r     <= {USER_W{1'b0}};
      pkt_count_r <= {CNT_W{1'b0}};
    end else begin
      in_ready_r <= !full_next_s;
      if (pop_s) begin
        tvalid_r <= 1'b1;
        tdata_r  <= head_data_s;
        tlast_r  <= head_last_s;
        tdest_r  <= beat_dest_s;
        tuser_r  <= beat_user_s;
        dest_r   <= beat_dest_s;
        state_r  <= state_next_s;
      end else if (hs_s) begin
        // Beat taken and nothing buffered behind it.
        tvalid_r <= 1'b0;
      end
      if (hs_s && tlast_r) begin
        pkt_count_r <= pkt_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready      = in_ready_r;
  assign busy          = !empty_s || tvalid_r;
  assign pkt_count     = pkt_count_r;
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tdata  = tdata_r;
  assign m_axis.tlast  = tlast_r;
  assign m_axis.tdest  = tdest_r;
  assign m_axis.tuser  = tuser_r;

  // full_s is only needed inside the FIFO's push gating.
  logic unused_s;
  assign unused_s = full_s;

endmodule
